key_scan_multi: RTL



---
 rtl/key_scan_multi_pkg.sv | 21 ++
 rtl/key_scan_multi_if.sv | 26 ++
 rtl/key_scan_multi_channel.sv | 166 ++++++++++++++++
 rtl/key_scan_multi.sv | 51 +++++
 4 files changed

// File: rtl/key_scan_multi_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel key processor.
package key_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DB_PRESS  = 3'd1,
      HELD      = 3'd2,
      LONG_HELD = 3'd3,
      DB_REL    = 3'd4
   } key_st_t;

   function automatic int unsigned ms_to_cyc(input int unsigned ms, input int unsigned hz);
      return ms * (hz / 1000);
   endfunction

   // A zero maximum still needs a 1-bit counter to keep declarations legal.
   function automatic int cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/key_scan_multi_if.sv
// Key bundle between the board pins / consumers and the key processor.
interface key_scan_multi_if #(
   parameter int N_KEYS = 4
);
   logic [N_KEYS-1:0] in_key;
   logic [N_KEYS-1:0] key_state;
   logic [N_KEYS-1:0] out_key_short;
   logic [N_KEYS-1:0] out_key_long;
   logic [N_KEYS-1:0] out_key_repeat;

   modport master (
      output in_key,
      input  key_state,
      input  out_key_short,
      input  out_key_long,
      input  out_key_repeat
   );

   modport slave (
      input  in_key,
      output key_state,
      output out_key_short,
      output out_key_long,
      output out_key_repeat
   );
endinterface

// File: rtl/key_scan_multi_channel.sv
// One key channel: 2-flop synchroniser, debounce/hold FSM and short/long/repeat pulses.
module key_channel
   import key_pkg::*;
#(
   parameter int unsigned DB_CYC   = 500_000,
   parameter int unsigned LONG_CYC = 25_000_000,
   parameter int unsigned REP_CYC  = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key,
   output logic o_state,
   output logic o_short,
   output logic o_long,
   output logic o_repeat
);

   localparam int DBW = cnt_width(DB_CYC);
   localparam int HW  = cnt_width(LONG_CYC);
   localparam int RW  = cnt_width(REP_CYC);

   localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYC);
   localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYC - 1);
   localparam logic [RW-1:0]  REP_LAST  = RW'((REP_CYC > 0) ? REP_CYC - 1 : 0);
   localparam bit             REP_EN    = (REP_CYC > 0);

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_DB_PRESS  = DB_PRESS;
   localparam logic [2:0] ST_HELD      = HELD;
   localparam logic [2:0] ST_LONG_HELD = LONG_HELD;
   localparam logic [2:0] ST_DB_REL    = DB_REL;

   logic           r_sync_p0;
   logic           r_sync_p1;
   logic [2:0]     r_state;
   logic           r_org_long;
   logic [DBW-1:0] r_cnt;
   logic [HW-1:0]  r_hold;
   logic [RW-1:0]  r_rep;
   logic           r_key_state;
   logic           r_short;
   logic           r_long;
   logic           r_repeat;

   logic w_s;
   logic w_long_tick;
   logic w_rep_tick;
   logic w_rel_done;

   assign w_s         = r_sync_p1;
   assign w_long_tick = (r_hold == LONG_LAST);
   assign w_rep_tick  = REP_EN && (r_rep == REP_LAST);
   assign w_rel_done  = !w_s && (r_cnt == DB_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_p0   <= 1'b0;
         r_sync_p1   <= 1'b0;
         r_state     <= ST_IDLE;
         r_org_long  <= 1'b0;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_rep       <= '0;
         r_key_state <= 1'b0;
         r_short     <= 1'b0;
         r_long      <= 1'b0;
         r_repeat    <= 1'b0;
      end else begin
         // synchroniser stage boundary: p0 -> p1 feeds the FSM
         r_sync_p0 <= i_key;
         r_sync_p1 <= r_sync_p0;
         r_short   <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_s) begin
                  r_state <= ST_DB_PRESS;
                  r_cnt   <= DBW'(1);
               end
            end

            ST_DB_PRESS: begin
               if (!w_s) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DB_MAX) begin
                  r_state     <= ST_HELD;
                  r_key_state <= 1'b1;
                  r_hold      <= '0;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_HELD: begin
               r_hold <= r_hold + 1'b1;
               if (w_long_tick) begin
                  r_long <= 1'b1;
                  r_rep  <= '0;
               end
               if (!w_s) begin
                  r_state    <= ST_DB_REL;
                  r_org_long <= w_long_tick;
                  r_cnt      <= DBW'(1);
               end else begin
                  r_state <= w_long_tick ? ST_LONG_HELD : ST_HELD;
                  r_cnt   <= '0;
               end
            end

            ST_LONG_HELD: begin
               if (REP_EN) begin
                  r_repeat <= w_rep_tick;
                  r_rep    <= w_rep_tick ? '0 : r_rep + 1'b1;
               end
               if (!w_s) begin
                  r_state    <= ST_DB_REL;
                  r_org_long <= 1'b1;
                  r_cnt      <= DBW'(1);
               end else begin
                  r_cnt <= '0;
               end
            end

            ST_DB_REL: begin
               // A completing release swallows any long/repeat tick of the same cycle.
               if (w_rel_done) begin
                  r_state     <= ST_IDLE;
                  r_key_state <= 1'b0;
                  r_short     <= !r_org_long;
                  r_cnt       <= '0;
               end else begin
                  if (!r_org_long) begin
                     r_hold <= r_hold + 1'b1;
                     if (w_long_tick) begin
                        r_long     <= 1'b1;
                        r_org_long <= 1'b1;
                        r_rep      <= '0;
                     end
                  end else if (REP_EN) begin
                     r_repeat <= w_rep_tick;
                     r_rep    <= w_rep_tick ? '0 : r_rep + 1'b1;
                  end
                  if (w_s) begin
                     r_state <= (r_org_long || w_long_tick) ? ST_LONG_HELD : ST_HELD;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_state  = r_key_state;
   assign o_short  = r_short;
   assign o_long   = r_long;
   assign o_repeat = r_repeat;

endmodule

// File: rtl/key_scan_multi.sv
// N independent push-button channels: polarity fix-up, then per-channel debounce and event classification.
module key_scan_multi
   import key_pkg::*;
#(
   parameter int          N_KEYS      = 4,
   parameter int unsigned IN_C_HZ     = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned LONG_MS     = 500,
   parameter int unsigned REPEAT_MS   = 100,
   parameter bit          ACTIVE_LOW  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   key_scan_multi_if.slave   bus
);

   localparam int unsigned DB_CYC   = ms_to_cyc(DEBOUNCE_MS, IN_C_HZ);
   localparam int unsigned LONG_CYC = ms_to_cyc(LONG_MS, IN_C_HZ);
   localparam int unsigned REP_CYC  = ms_to_cyc(REPEAT_MS, IN_C_HZ);

   logic [N_KEYS-1:0] w_key;
   logic [N_KEYS-1:0] w_state;
   logic [N_KEYS-1:0] w_short;
   logic [N_KEYS-1:0] w_long;
   logic [N_KEYS-1:0] w_repeat;

   // Inversion sits ahead of the synchroniser so its reset level means "released".
   assign w_key = ACTIVE_LOW ? ~bus.in_key : bus.in_key;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_channel #(
         .DB_CYC   (DB_CYC),
         .LONG_CYC (LONG_CYC),
         .REP_CYC  (REP_CYC)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_key    (w_key[g]),
         .o_state  (w_state[g]),
         .o_short  (w_short[g]),
         .o_long   (w_long[g]),
         .o_repeat (w_repeat[g])
      );
   end

   assign bus.key_state      = w_state;
   assign bus.out_key_short  = w_short;
   assign bus.out_key_long   = w_long;
   assign bus.out_key_repeat = w_repeat;

endmodule
